// File: rtl/cond_wb_unit.sv
// Condition evaluation, NZCV flag register, strobe gating and two-beat long-multiply write-back.
// Optional FLAG_FWD_EN: CondSample evaluates Cond against the forwarded next-state flags.
module cond_wb_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagW,
    input  logic              CondSample,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              NoWrite,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [3:0]        Flags,
    output logic              CondEx,
    input  logic              LongWB,
    input  logic [WIDTH-1:0]  Result,
    input  logic [WIDTH-1:0]  Result2,
    input  logic [ADDR_W-1:0] RdLo,
    input  logic [ADDR_W-1:0] RdHi,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

    state_t            state, state_next;
    logic [3:0]        flags_next;
    logic [3:0]        eval_flags;
    logic [WIDTH-1:0]  lo_word, hi_word;
    logic [ADDR_W-1:0] rd_lo, rd_hi;
    logic              start_long;

    // Flags are {N,Z,C,V}; encoding 4'hF is "never".
    function automatic logic cond_met(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    cond_met = z;
            4'h1:    cond_met = !z;
            4'h2:    cond_met = cf;
            4'h3:    cond_met = !cf;
            4'h4:    cond_met = n;
            4'h5:    cond_met = !n;
            4'h6:    cond_met = v;
            4'h7:    cond_met = !v;
            4'h8:    cond_met = cf && !z;
            4'h9:    cond_met = !cf || z;
            4'hA:    cond_met = (n == v);
            4'hB:    cond_met = (n != v);
            4'hC:    cond_met = !z && (n == v);
            4'hD:    cond_met = z || (n != v);
            4'hE:    cond_met = 1'b1;
            default: cond_met = 1'b0;
        endcase
    endfunction

    always_comb begin
        flags_next = Flags;
        if (CondEx && FlagW[1]) flags_next[3:2] = ALUFlags[3:2];
        if (CondEx && FlagW[0]) flags_next[1:0] = ALUFlags[1:0];
    end

`ifdef FLAG_FWD_EN
    assign eval_flags = flags_next;
`else
    assign eval_flags = Flags;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags  <= 4'b0000;
            CondEx <= 1'b0;
        end else begin
            Flags <= flags_next;
            if (CondSample) CondEx <= cond_met(Cond, eval_flags);
        end
    end

    assign PCWrite  = PCS && CondEx;
    assign RegWrite = RegW && CondEx && !NoWrite;
    assign MemWrite = MemW && CondEx;

    assign start_long = (state == S_IDLE) && LongWB && CondEx;

    // NOTE: the capture registers are ordinary flops, not a memory array, so resetting them is cheap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            lo_word <= '0;
            hi_word <= '0;
            rd_lo   <= '0;
            rd_hi   <= '0;
        end else begin
            state <= state_next;
            if (start_long) begin
                lo_word <= Result;
                hi_word <= Result2;
                rd_lo   <= RdLo;
                rd_hi   <= RdHi;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        case (state)
            S_IDLE: if (start_long) state_next = S_LO;
            S_LO: begin
                wb_valid = 1'b1;
                wb_addr  = rd_lo;
                wb_data  = lo_word;
                if (wb_ready) state_next = S_HI;
            end
            S_HI: begin
                wb_valid = 1'b1;
                wb_addr  = rd_hi;
                wb_data  = hi_word;
                if (wb_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_cond_wb_unit.sv
// Self-checking bench for cond_wb_unit: directed scenarios plus random stimulus against a
// behavioural model; expected write beats are queued and popped by the negedge monitor.
module tb_cond_wb_unit;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        CondSample, PCS, RegW, MemW, NoWrite;
    logic        PCWrite, RegWrite, MemWrite;
    logic [3:0]  Flags;
    logic        CondEx;
    logic        LongWB;
    logic [31:0] Result, Result2;
    logic [3:0]  RdLo, RdHi;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        busy;

    cond_wb_unit #(.WIDTH(32), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .CondSample(CondSample), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
        .CondEx(CondEx), .LongWB(LongWB), .Result(Result), .Result2(Result2),
        .RdLo(RdLo), .RdHi(RdHi), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] m_flags;
    bit         m_condex;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Standard condition pairs: odd codes invert the even code's test.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return base ^ c[0];
    endfunction

    // Monitor + model: inputs are stable at the falling edge and are what the next rising edge samples.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_flags  = 4'b0000;
            m_condex = 1'b0;
        end else begin
            bit         was_busy, cx_new;
            logic [3:0] nf;
            was_busy = (exp_q.size() != 0);
            check("flags", Flags, m_flags);
            check("cond_ex", CondEx, m_condex);
            check("pc_write", PCWrite, PCS && m_condex);
            check("reg_write", RegWrite, RegW && m_condex && !NoWrite);
            check("mem_write", MemWrite, MemW && m_condex);
            check("busy", busy, was_busy);
            check("wb_valid", wb_valid, was_busy);
            if (wb_valid && was_busy) begin
                check("wb_addr", wb_addr, exp_q[0].addr);
                check("wb_data", wb_data, exp_q[0].data);
                if (wb_ready) void'(exp_q.pop_front());
            end
            nf = m_flags;
            if (m_condex && FlagW[1]) nf[3:2] = ALUFlags[3:2];
            if (m_condex && FlagW[0]) nf[1:0] = ALUFlags[1:0];
            cx_new = m_condex;
            if (CondSample) cx_new = ref_cond(Cond, FWD ? nf : m_flags);
            if (LongWB && m_condex && !was_busy) begin
                exp_q.push_back('{addr: RdLo, data: Result});
                exp_q.push_back('{addr: RdHi, data: Result2});
            end
            m_flags  = nf;
            m_condex = cx_new;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00; CondSample = 1'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
        LongWB = 1'b0; wb_ready = 1'b0;
    endtask

    // Sets CondEx=1 via an AL sample, leaving the flag register untouched.
    task automatic make_condex();
        idle_inputs();
        Cond = 4'hE; CondSample = 1'b1;
        step();
        CondSample = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        Result = '0; Result2 = '0; RdLo = '0; RdHi = '0;
        repeat (2) step();
        check("reset_flags", Flags, 4'b0000);
        check("reset_busy", busy, 1'b0);
        reset = 1'b1;
        step();

        // Flags -> Z only; EQ passes, NE fails, AL blocked by NoWrite.
        make_condex();
        FlagW = 2'b11; ALUFlags = 4'b0100;
        step();
        FlagW = 2'b00; Cond = 4'h0; CondSample = 1'b1; RegW = 1'b1;
        step();
        check("eq_reg_write", RegWrite, 1'b1);
        Cond = 4'h1;
        step();
        check("ne_reg_write", RegWrite, 1'b0);
        Cond = 4'hE;
        step();
        NoWrite = 1'b1;
        #1 check("nowrite_reg_write", RegWrite, 1'b0);
        NoWrite = 1'b0; RegW = 1'b0; CondSample = 1'b0;

        // Only the N,Z half loads.
        FlagW = 2'b11; ALUFlags = 4'b0000;
        step();
        check("flags_cleared", Flags, 4'b0000);
        FlagW = 2'b10; ALUFlags = 4'b1011;
        step();
        check("flags_nz_only", Flags, 4'b1000);
        FlagW = 2'b00;

        // Long write-back with ready always high.
        LongWB = 1'b1; Result = 32'h89AB_CDEF; Result2 = 32'h0123_4567;
        RdLo = 4'd2; RdHi = 4'd3; wb_ready = 1'b1;
        step();
        LongWB = 1'b0;
        check("lo_addr", wb_addr, 4'd2);
        check("lo_data", wb_data, 32'h89AB_CDEF);
        step();
        check("hi_addr", wb_addr, 4'd3);
        check("hi_data", wb_data, 32'h0123_4567);
        step();
        check("busy_after_hi", busy, 1'b0);

        // Stall in LO, then reset while in HI.
        LongWB = 1'b1; wb_ready = 1'b0;
        step();
        LongWB = 1'b0;
        repeat (3) begin
            check("stall_addr", wb_addr, 4'd2);
            check("stall_data", wb_data, 32'h89AB_CDEF);
            step();
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        check("in_hi_valid", wb_valid, 1'b1);
        reset = 1'b0;
        #1;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", Flags, 4'b0000);
        check("rst_cond_ex", CondEx, 1'b0);
        step();
        reset = 1'b1;
        step();

        // Same-cycle flag update versus condition sample.
        make_condex();
        FlagW = 2'b11; ALUFlags = 4'b0000;
        step();
        FlagW = 2'b10; ALUFlags = 4'b0100; Cond = 4'h0; CondSample = 1'b1;
        step();
        check("fwd_cond_ex", CondEx, FWD);
        idle_inputs();

        // Same destination for both beats.
        make_condex();
        LongWB = 1'b1; RdLo = 4'd7; RdHi = 4'd7; wb_ready = 1'b1;
        Result = 32'hDEAD_BEEF; Result2 = 32'hCAFE_F00D;
        step();
        LongWB = 1'b0;
        repeat (3) step();

        // Random traffic, with rare resets.
        for (int i = 0; i < 600; i++) begin
            Cond       = 4'($urandom_range(15));
            ALUFlags   = 4'($urandom_range(15));
            FlagW      = 2'($urandom_range(3));
            CondSample = ($urandom_range(3) == 0);
            PCS        = 1'($urandom_range(1));
            RegW       = 1'($urandom_range(1));
            MemW       = 1'($urandom_range(1));
            NoWrite    = ($urandom_range(3) == 0);
            LongWB     = ($urandom_range(2) == 0);
            wb_ready   = ($urandom_range(4) != 0);
            Result     = $urandom;
            Result2    = $urandom;
            RdLo       = 4'($urandom_range(15));
            RdHi       = 4'($urandom_range(15));
            reset      = ($urandom_range(99) != 0);
            step();
        end
        reset = 1'b1;
        idle_inputs();
        wb_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
